// File: rtl/snek_pkg.sv
// Shared encodings for the snake game sequencer: FSM states, heading, grid geometry.
package snek_pkg;

    typedef enum logic [1:0] {
        ST_SPLASH   = 2'd0,
        ST_PLAY     = 2'd1,
        ST_GAMEOVER = 2'd2,
        ST_UNUSED   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    localparam int GRID_H  = 32;
    localparam int COORD_W = $clog2(GRID_H);

    // Opposite headings share the axis bit and differ only in the sign bit.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/dir_latch.sv
// Button front end: priority encode into a pending heading, edge detect, and
// commit of the pending heading on a play frame unless it would reverse the snake.
module dir_latch
    import snek_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] buttons,
    input  logic       frame_tick,
    input  logic       play,
    input  logic       load,
    output logic [1:0] dir,
    output logic       any_edge
);

    logic [3:0] btn_prev;
    dir_t       pend;
    dir_t       dir_q;
    dir_t       sel;

    // buttons = {down, up, left, right}; priority left > right > up > down
    always_comb begin
        sel = pend;
        if (buttons[1])      sel = DIR_LEFT;
        else if (buttons[0]) sel = DIR_RIGHT;
        else if (buttons[2]) sel = DIR_UP;
        else if (buttons[3]) sel = DIR_DOWN;
    end

    assign any_edge = |(buttons & ~btn_prev);
    assign dir      = dir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev <= '0;
            pend     <= DIR_RIGHT;
            dir_q    <= DIR_RIGHT;
        end else begin
            btn_prev <= buttons;
            if (load) begin
                pend  <= DIR_RIGHT;
                dir_q <= DIR_RIGHT;
            end else begin
                pend <= sel;
                if (play && frame_tick && !is_reverse(pend, dir_q))
                    dir_q <= pend;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-level sequencer for the snake game: splash/play/gameover flow, eat and
// collision handling, score keeping, with all outputs registered.
module game_sequencer
    import snek_pkg::*;
#(
    parameter int SPLASH_FRAMES   = 16,
    parameter int GAMEOVER_FRAMES = 32,
    parameter int GRID_V          = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         buttons,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] head_h,
    input  logic [COORD_W-1:0] head_v,
    input  logic [COORD_W-1:0] food_h,
    input  logic [COORD_W-1:0] food_v,
    input  logic               self_hit,
    output logic [1:0]         state,
    output logic               run,
    output logic [1:0]         dir,
    output logic               grow_flag,
    output logic               new_food_flag,
    output logic               newgame,
    output logic [7:0]         score
);

    localparam int CNT_MAX = (SPLASH_FRAMES > GAMEOVER_FRAMES) ? SPLASH_FRAMES : GAMEOVER_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    score_n;
    logic          eat_n;
    logic          enter_play;
    logic          any_edge;
    logic          hit;

    assign hit   = (int'(head_v) >= GRID_V) || self_hit;
    assign state = st;

    dir_latch u_dir_latch (
        .clk        (clk),
        .rst        (rst),
        .buttons    (buttons),
        .frame_tick (frame_tick),
        .play       (st == ST_PLAY),
        .load       (enter_play),
        .dir        (dir),
        .any_edge   (any_edge)
    );

    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        score_n = score;
        eat_n   = 1'b0;
        case (st)
            ST_SPLASH: begin
                if (frame_tick)
                    cnt_n = cnt + 1'b1;
                if ((frame_tick && cnt == CW'(SPLASH_FRAMES - 1)) || any_edge)
                    st_n = ST_PLAY;
            end
            ST_PLAY: begin
                // a collision wins over an eat on the same frame
                if (frame_tick) begin
                    if (hit) begin
                        st_n = ST_GAMEOVER;
                    end else if (head_h == food_h && head_v == food_v) begin
                        eat_n = 1'b1;
                        if (score != 8'hFF)
                            score_n = score + 8'd1;
                    end
                end
            end
            ST_GAMEOVER: begin
                if (cnt == CW'(GAMEOVER_FRAMES)) begin
                    if (any_edge)
                        st_n = ST_PLAY;
                end else if (frame_tick) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: st_n = ST_SPLASH;
        endcase

        enter_play = (st_n == ST_PLAY) && (st != ST_PLAY);
        if (st_n != st)
            cnt_n = '0;
        if (enter_play)
            score_n = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st            <= ST_SPLASH;
            cnt           <= '0;
            score         <= '0;
            run           <= 1'b0;
            grow_flag     <= 1'b0;
            new_food_flag <= 1'b0;
            newgame       <= 1'b0;
        end else begin
            st            <= st_n;
            cnt           <= cnt_n;
            score         <= score_n;
            run           <= (st_n == ST_PLAY);
            grow_flag     <= eat_n;
            new_food_flag <= eat_n;
            newgame       <= enter_play;
        end
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter SPLASH_FRAMES, default 16, frame ticks spent in SPLASH before auto-start.
REQ-002 SHALL have parameter GAMEOVER_FRAMES, default 32, frame ticks in GAMEOVER before a button press is accepted.
REQ-003 SHALL have parameter GRID_V, default 24, number of valid vertical grid rows; the horizontal grid is 32 columns, with all 5-bit values valid.
REQ-004 SHALL have ports: clk in 1, system clock; rst in 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports: buttons in 4, raw direction buttons {down,up,left,right} = [3:0]; frame_tick in 1, one-clk pulse per game frame.
REQ-006 SHALL have ports: head_h in 5 and head_v in 5, snake head cell; food_h in 5 and food_v in 5, food cell; self_hit in 1, head overlaps body (valid at frame_tick).
REQ-007 SHALL have ports: state out 2 (0=SPLASH, 1=PLAY, 2=GAMEOVER); run out 1, high only in PLAY; dir out 2 (0=left, 1=right, 2=up, 3=down).
REQ-008 SHALL have ports: grow_flag out 1, new_food_flag out 1, newgame out 1 (each a one-clk pulse); score out 8.

Function
REQ-009 SHALL implement the FSM SPLASH->PLAY->GAMEOVER->PLAY; encoding 3 is unused and SHALL return to SPLASH on the next clk.
REQ-010 SPLASH SHALL count frame_tick pulses and go to PLAY on tick SPLASH_FRAMES or on any button edge, whichever comes first.
REQ-011 Entry to PLAY SHALL pulse newgame for 1 clk, clear score to 0, set dir=1 (right) and clear the pending direction.
REQ-012 Buttons SHALL be sampled every clk with priority left>right>up>down into a pending register; if no button is pressed, pending holds.
REQ-013 The pending direction SHALL commit to dir only on frame_tick in PLAY; a pending value that reverses dir (left<->right, up<->down) SHALL be discarded.
REQ-014 On frame_tick in PLAY, a wall hit (head_v >= GRID_V) or self_hit SHALL go to GAMEOVER on the next clk.
REQ-015 On frame_tick in PLAY with head==food and no collision, the block SHALL pulse grow_flag and new_food_flag in the same cycle, 1 clk after the tick.
REQ-016 Score SHALL increment by 1 on each eat, saturating at 255.
REQ-017 A collision and an eat on the same tick SHALL produce GAMEOVER only: no grow pulse, no score change.
REQ-018 GAMEOVER SHALL hold score and dir, and count frame_tick pulses up to GAMEOVER_FRAMES.
REQ-019 Once that count is reached, a button rising edge SHALL go to PLAY with the entry actions of REQ-011.
REQ-020 Button edges SHALL be detected against a registered previous value of buttons; a held button SHALL NOT retrigger.
REQ-021 frame_tick asserted outside PLAY SHALL NOT affect dir, score, grow_flag or new_food_flag.
REQ-022 The frame counter SHALL reset to 0 on every state change and saturate at its terminal value.

Reset
REQ-023 On rst high, asynchronously: state=SPLASH, run=0, dir=1, pending=1, score=0, all pulses=0, counters=0, button history=0.
REQ-024 Reset asserted mid-game SHALL abort immediately with no newgame pulse; after release the block SHALL restart in SPLASH.

Structure
REQ-025 The state encoding, direction encoding and grid width SHALL live in the shared package snek_pkg.
REQ-026 One sub-module, dir_latch, SHALL hold the button priority encode, edge detect, pending register and reversal filter.
REQ-027 All outputs SHALL be registered, and the block SHALL use a single clock domain.

Verification
REQ-028 Reset, then 16 frame_ticks with no buttons -> state=1, newgame pulses once, dir=1, score=0.
REQ-029 In PLAY with dir=1, press left then frame_tick -> dir stays 1; press up then frame_tick -> dir=2.
REQ-030 head=(5,5), food=(5,5), frame_tick -> grow_flag and new_food_flag high for exactly 1 clk, score 0->1; after 260 eats, score=255.
REQ-031 head_v=24 with frame_tick -> state=2; with head==food and self_hit=1 on the same tick -> state=2, score unchanged, no grow pulse.
REQ-032 In GAMEOVER, a press at tick 10 is ignored; a press after tick 32 -> state=1, score=0, newgame pulse.
REQ-033 Assert rst while in PLAY with score=7 -> state=0 and score=0 immediately; dir=1.
